// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 keyboard deframer with E0/F0 prefix stripping (optional PS2_BREAK_REPORT_EN)
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       data_ready,
    output logic       key_ext,
    output logic       key_release,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t         state, state_nxt;
    logic           clk_s1, clk_s2, data_s1, data_s2;
    logic           filt_level;
    logic [FCW-1:0] filt_cnt;
    logic           fall;
    logic [7:0]     shift_reg;
    logic [2:0]     bit_cnt;
    logic           par_bit;
    logic [TW-1:0]  tmo_cnt;
    logic           timeout;
    logic           frame_ok, frame_bad;
    logic           ext_flag, brk_flag;

    // Two-stage synchronizers; both lines idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Glitch filter: level flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_level <= 1'b1;
            filt_cnt   <= '0;
        end else if (clk_s2 == filt_level) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            filt_level <= clk_s2;
            filt_cnt   <= '0;
        end else begin
            filt_cnt <= filt_cnt + FCW'(1);
        end
    end

    // Falling edge is the cycle in which the filtered level is about to go 1->0
    assign fall = filt_level && !clk_s2 && (filt_cnt == FCW'(FILTER_LEN - 1));

    // Inactivity counter; only meaningful while a frame is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE || fall || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign timeout = (state != S_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Deframer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Deframer next-state and frame verdict
    always_comb begin
        state_nxt = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (timeout) begin
            state_nxt = S_IDLE;
            frame_bad = 1'b1;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!data_s2) state_nxt = S_DATA;
                    else          frame_bad = 1'b1;
                end
                S_DATA: begin
                    if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                end
                S_PARITY: state_nxt = S_STOP;
                S_STOP: begin
                    if (data_s2 && (^{shift_reg, par_bit})) frame_ok  = 1'b1;
                    else                                    frame_bad = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Bit capture: data LSB first, then parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
        end else if (fall) begin
            case (state)
                S_IDLE:   bit_cnt <= '0;
                S_DATA: begin
                    shift_reg <= {data_s2, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                S_PARITY: par_bit <= data_s2;
                default:  ;
            endcase
        end
    end

    // Prefix tracking and registered key outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            key_code   <= '0;
            key_ext    <= 1'b0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PS2_BREAK_REPORT_EN
            key_release <= 1'b0;
`endif
        end else begin
            data_ready <= 1'b0;
            frame_err  <= frame_bad;
            if (frame_bad) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (frame_ok) begin
                if (shift_reg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
`ifdef PS2_BREAK_REPORT_EN
                    data_ready  <= 1'b1;
                    key_code    <= shift_reg;
                    key_ext     <= ext_flag;
                    key_release <= brk_flag;
`else
                    if (!brk_flag) begin
                        data_ready <= 1'b1;
                        key_code   <= shift_reg;
                        key_ext    <= ext_flag;
                    end
`endif
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end
        end
    end

`ifndef PS2_BREAK_REPORT_EN
    assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb/tb_ps2_keycode_rx.sv - self-checking bench for ps2_keycode_rx
module tb_ps2_keycode_rx;

    localparam int FL  = 4;
    localparam int TMO = 2000;
    localparam int H   = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       data_ready, key_ext, key_release, frame_err;

    ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_code(key_code), .data_ready(data_ready), .key_ext(key_ext),
        .key_release(key_release), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    always @(posedge clk) cyc++;

    int         dr_cnt = 0, err_cnt = 0, dr_cyc = 0, dbl = 0;
    logic       prev_dr = 1'b0;
    logic [7:0] last_code = '0;
    logic       last_ext = 1'b0, last_rel = 1'b0;
    bit         rec_en = 1'b0;
    logic [9:0] act_q[$];
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (data_ready) begin
            dr_cnt++;
            dr_cyc    = cyc;
            last_code = key_code;
            last_ext  = key_ext;
            last_rel  = key_release;
            if (rec_en) act_q.push_back({key_release, key_ext, key_code});
        end
        if (frame_err) err_cnt++;
        if (data_ready && prev_dr) dbl++;
        prev_dr = data_ready;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (H / 2) @(negedge clk);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (H / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data_ready"}, data_ready, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_key_code"}, key_code, 0);
        check({tag, "_key_ext"}, key_ext, 0);
        check({tag, "_key_release"}, key_release, 0);
    endtask

    typedef struct {
        logic [23:0] bytes;
        int          n;
        logic [2:0]  bad;
        int          pulses;
        int          errs;
        logic [7:0]  code;
        logic        ext;
        logic        rel;
    } vec_t;

    vec_t vt[10];

    initial begin
        int p0, e0, exp_err;
        bit m_ext, m_brk;

        vt[0] = '{24'h00001C, 1, 3'b000, 1, 0, 8'h1C, 1'b0, 1'b0};
        vt[1] = '{24'h006BE0, 2, 3'b000, 1, 0, 8'h6B, 1'b1, 1'b0};
        vt[2] = '{24'h0074E0, 2, 3'b000, 1, 0, 8'h74, 1'b1, 1'b0};
        vt[3] = '{24'h0075E0, 2, 3'b000, 1, 0, 8'h75, 1'b1, 1'b0};
`ifdef PS2_BREAK_REPORT_EN
        vt[4] = '{24'h001CF0, 2, 3'b000, 1, 0, 8'h1C, 1'b0, 1'b1};
`else
        vt[4] = '{24'h001CF0, 2, 3'b000, 0, 0, 8'h00, 1'b0, 1'b0};
`endif
        vt[5] = '{24'h00001C, 1, 3'b000, 1, 0, 8'h1C, 1'b0, 1'b0};
        vt[6] = '{24'h00001C, 1, 3'b001, 0, 1, 8'h00, 1'b0, 1'b0};
        vt[7] = '{24'h006BE0, 2, 3'b010, 0, 1, 8'h00, 1'b0, 1'b0};
        vt[8] = '{24'h00006B, 1, 3'b000, 1, 0, 8'h6B, 1'b0, 1'b0};
        vt[9] = '{24'h1CE0E0, 3, 3'b000, 1, 0, 8'h1C, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            p0 = dr_cnt;
            e0 = err_cnt;
            for (int k = 0; k < vt[v].n; k++)
                send_bits(vt[v].bytes[8*k +: 8], vt[v].bad[k], 11);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_pulses", v), dr_cnt - p0, vt[v].pulses);
            check($sformatf("vec%0d_errs", v), err_cnt - e0, vt[v].errs);
            if (vt[v].pulses > 0) begin
                check($sformatf("vec%0d_code", v), last_code, vt[v].code);
                check($sformatf("vec%0d_ext", v), last_ext, vt[v].ext);
                check($sformatf("vec%0d_rel", v), last_rel, vt[v].rel);
            end
            if (v == 0) check("latency", dr_cyc - last_fall, 2 + FL);
        end

        // abandoned frame: clock stops after five data bits
        p0 = dr_cnt;
        e0 = err_cnt;
        send_bits(8'h1C, 1'b0, 6);
        repeat (TMO + 100) @(negedge clk);
        check("timeout_errs", err_cnt - e0, 1);
        check("timeout_pulses", dr_cnt - p0, 0);
        send_bits(8'h1C, 1'b0, 11);
        repeat (20) @(negedge clk);
        check("post_timeout_pulses", dr_cnt - p0, 1);
        check("post_timeout_code", last_code, 8'h1C);

        // reset mid-frame with short glitches on the clock line
        p0 = dr_cnt;
        e0 = err_cnt;
        send_bits(8'h6B, 1'b0, 4);
        #3 rst_n = 1'b0;
        ps2_data = 1'b1;
        repeat (5) begin
            #7 ps2_clk = 1'b0;
            #2 ps2_clk = 1'b1;
        end
        @(negedge clk);
        check_zero_outputs("midreset");
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1 ps2_clk = 1'b0;
            #2 ps2_clk = 1'b1;
        end
        repeat (50) @(negedge clk);
        check("glitch_pulses", dr_cnt - p0, 0);
        check("glitch_errs", err_cnt - e0, 0);
        send_bits(8'h1C, 1'b0, 11);
        repeat (20) @(negedge clk);
        check("post_reset_pulses", dr_cnt - p0, 1);
        check("post_reset_code", last_code, 8'h1C);
        check("post_reset_ext", last_ext, 0);

        // random byte stream against a prefix-stripping reference model
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_err = 0;
        e0 = err_cnt;
        rec_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            bit bad;
            int r;
            r = $urandom_range(0, 99);
            if (r < 20)      b = 8'hE0;
            else if (r < 35) b = 8'hF0;
            else             b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            send_bits(b, bad, 11);
            if (bad) begin
                exp_err++;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
`ifdef PS2_BREAK_REPORT_EN
                exp_q.push_back({m_brk, m_ext, b});
`else
                if (!m_brk) exp_q.push_back({1'b0, m_ext, b});
`endif
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        repeat (20) @(negedge clk);
        rec_en = 1'b0;
        check("rand_count", act_q.size(), exp_q.size());
        check("rand_errs", err_cnt - e0, exp_err);
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("rand_event%0d", i), act_q[i], exp_q[i]);

        check("no_back_to_back", dbl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
- PS/2 keyboard receiver that produces the `key_code` / `data_ready` pair consumed by the keycode store block.
- Samples the asynchronous `ps2_clk` / `ps2_data` lines and deframes 11-bit device-to-host frames.
- Strips the E0 (extended) and F0 (break) prefixes and emits one single-cycle `data_ready` pulse per key make event.
- Sits between the keyboard pins and the memory-mapped keycode store.

Parameters:
- FILTER_LEN, 4: number of consecutive identical synchronized `ps2_clk` samples required to accept a level change (glitch filter).
- TIMEOUT_CYCLES, 100000: `clk` cycles without an accepted `ps2_clk` falling edge before a partial frame is abandoned (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  PS/2 clock line, asynchronous, idle high
- ps2_data  in  1  PS/2 data line, asynchronous, idle high
- key_code  out  8  last accepted make code (prefixes removed)
- data_ready  out  1  one-cycle pulse; `key_code` / `key_ext` / `key_release` are valid in that cycle
- key_ext  out  1  1 when the code was preceded by E0
- key_release  out  1  1 for a break event (only with the optional feature; otherwise constant 0)
- frame_err  out  1  one-cycle pulse on a start, parity or stop error, or on a timeout

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, prefix flags cleared, filter state = 1 (line idle high).
- Input conditioning:
  - Two-FF synchronizer on both lines.
  - `ps2_clk` passes through the FILTER_LEN glitch filter.
  - A falling edge = filtered level changes 1->0; `ps2_data` (synchronized) is sampled in that same cycle.
- Deframer FSM, advanced only on falling edges (except timeout):
  - IDLE: sampled bit 0 -> DATA, bit count = 0. Sampled bit 1 -> frame_err pulse, stay in IDLE.
  - DATA: shift the bit in, LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: stop bit = 1 and odd parity holds (ones in data + parity is odd) -> frame accepted. Otherwise frame_err. Either way -> IDLE.
- Timeout: counter clears on every falling edge and runs in any state except IDLE. On reaching TIMEOUT_CYCLES: frame_err pulse, FSM -> IDLE, prefix flags cleared.
- Decode of an accepted byte (same cycle as acceptance):
  - E0: set ext_flag, no output.
  - F0: set brk_flag, no output.
  - Any other byte with brk_flag = 0: register `key_code` = byte and `key_ext` = ext_flag; pulse `data_ready` in the next cycle; clear both flags.
  - Any other byte with brk_flag = 1: no pulse; clear both flags.
- Latency: `data_ready` is high exactly one `clk` cycle after the cycle in which the stop-bit falling edge is detected.
- Output hold: `key_code` and `key_ext` hold their values until the next pulse. `data_ready` is never high two cycles in a row.
- Any frame error also clears ext_flag and brk_flag.
- E0 followed by E0: ext_flag stays set.
- Reset mid-frame: partial frame discarded, no pulse.

Optional Feature:
- Macro: PS2_BREAK_REPORT_EN
- Defined: a non-prefix byte with brk_flag = 1 also pulses `data_ready`, with `key_release` = 1, `key_code` = byte and `key_ext` = ext_flag. Make events drive `key_release` = 0.
- Undefined: break events are silently consumed and `key_release` is tied to 0.

Test Plan:
- Frame 0x1C (data 00111000 LSB first, parity 0, stop 1) at a 10 kHz `ps2_clk` -> exactly one `data_ready` pulse, `key_code` = 1C, `key_ext` = 0, `frame_err` never asserted.
- Frames E0, 6B -> a single pulse after the second frame with `key_code` = 6B, `key_ext` = 1; repeat for E0 74 and E0 75 -> 74 and 75, each with `key_ext` = 1.
- Frames F0, 1C:
  - Macro undefined -> no pulse.
  - Macro defined -> one pulse with `key_code` = 1C, `key_release` = 1.
  - Following frame 1C -> pulse with `key_release` = 0.
- Frame 0x1C with parity bit 1 -> `frame_err` pulse, no `data_ready`. Then E0 bad-parity 6B, then a valid 6B -> pulse with `key_ext` = 0 (flag was cleared by the error).
- Stop driving `ps2_clk` after 5 data bits for more than 100000 cycles -> one `frame_err` pulse. A subsequent valid 0x1C frame -> normal pulse.
- Assert `rst_n` low mid-frame, then send 2 ns glitches on `ps2_clk` -> no pulse and outputs at 0. The next valid frame is received correctly.
